// File: rtl/dpram_clr_param.sv
// Parametrised single-clock true-dual-port RAM with a hardware clear engine,
// port-A-wins write-collision arbitration and a one-cycle collision flag.
module dpram_clr_param #(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       ADDR_W       = 14,
    parameter int unsigned       OUT_REG      = 0,
    parameter int unsigned       WRITE_MODE   = 0,
    parameter logic [DATA_W-1:0] FILL_VALUE   = '0,
    parameter bit                CLR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_collision,
    input  logic              cea,
    input  logic              ceb,
    input  logic              wrea,
    input  logic              wreb,
    input  logic              ocea,
    input  logic              oceb,
    input  logic [ADDR_W-1:0] ada,
    input  logic [ADDR_W-1:0] adb,
    input  logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] dinb,
    output logic [DATA_W-1:0] douta,
    output logic [DATA_W-1:0] doutb
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              clearing;

    logic              act_a;
    logic              act_b;
    logic              wr_a;
    logic              wr_b;
    logic              same_addr;
    logic              wr_b_ok;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Clear sweep: one word per cycle from 0 up to the last address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= CLR_ON_RESET ? CLEAR : IDLE;
            ptr      <= '0;
            clr_busy <= CLR_ON_RESET;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_ADDR) begin
                        ptr      <= '0;
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign clearing = (state == CLEAR);

    // User ports are completely gated off while the sweep owns the array.
    assign act_a     = cea & ~clearing;
    assign act_b     = ceb & ~clearing;
    assign wr_a      = act_a & wrea;
    assign wr_b      = act_b & wreb;
    assign same_addr = (ada == adb);
    assign wr_b_ok   = wr_b & ~(wr_a & same_addr);

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[ptr] <= FILL_VALUE;
        end else begin
            if (wr_a) begin
                mem[ada] <= dina;
            end
            if (wr_b_ok) begin
                mem[adb] <= dinb;
            end
        end
    end

    // Read regs sample pre-edge contents, so cross-port read-during-write sees old data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_a <= '0;
        end else if (act_a) begin
            if (!wrea) begin
                rd_a <= mem[ada];
            end else if (WRITE_MODE == 1) begin
                rd_a <= dina;
            end else if (WRITE_MODE == 2) begin
                rd_a <= mem[ada];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_b <= '0;
        end else if (act_b) begin
            if (!wreb) begin
                rd_b <= mem[adb];
            end else if (WRITE_MODE == 1) begin
                rd_b <= dinb;
            end else if (WRITE_MODE == 2) begin
                rd_b <= mem[adb];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= wr_a & wr_b & same_addr;
        end
    end

    // Optional output stage adds one cycle of latency, gated by oce.
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] oq_a;
            logic [DATA_W-1:0] oq_b;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    oq_a <= '0;
                    oq_b <= '0;
                end else begin
                    if (ocea) begin
                        oq_a <= rd_a;
                    end
                    if (oceb) begin
                        oq_b <= rd_b;
                    end
                end
            end

            assign douta = oq_a;
            assign doutb = oq_b;
        end else begin : g_noreg
            logic unused_oce;
            assign unused_oce = ocea ^ oceb;
            assign douta      = rd_a;
            assign doutb      = rd_b;
        end
    endgenerate

endmodule
